otter_id_operand_stage: RTL and testbench

- Decode-side operand stage of the pipelined OTTER core. It sits directly upstream of the register file.
- It takes the IF/ID instruction, drives the register-file read addresses, and resolves RAW hazards. Forwarding covers results from EX and MEM; a load-use case inserts a bubble.
- It registers operands and control into the ID/EX pipeline register consumed by EX.
- WB needs no bypass here: the register file writes on the falling clock edge, so same-cycle WB data is already visible on Data1/Data2.

---
 rtl/otter_pkg.sv | 43 ++++
 rtl/otter_operand_fwd.sv | 31 +++
 rtl/otter_id_operand_stage.sv | 127 ++++++++++++
 tb/tb_otter_id_operand_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared opcodes, constants and the ID/EX bundle for the OTTER pipeline.
// Also holds the decode helpers that tell which register fields an opcode uses.
package otter_pkg;

  localparam int unsigned OTTER_XLEN = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned OPC_W      = 7;

  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                  valid;
    logic [OTTER_XLEN-1:0] pc;
    logic [INSTR_W-1:0]    instr;
    logic [OTTER_XLEN-1:0] rs1_val;
    logic [OTTER_XLEN-1:0] rs2_val;
    logic [REG_AW-1:0]     rd;
  } idex_t;

  function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
    return !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
    return (opc == OP_REG || opc == OP_STORE || opc == OP_BRANCH);
  endfunction

  function automatic logic rd_valid(input logic [OPC_W-1:0] opc);
    return !(opc == OP_STORE || opc == OP_BRANCH);
  endfunction

endpackage

// File: rtl/otter_operand_fwd.sv
// Resolves one source operand: x0 guard, then EX bypass, then MEM bypass, then register file.
// Loads in EX are never bypassed; their data only exists once they reach MEM.
module otter_operand_fwd
  import otter_pkg::*;
#(
  parameter int unsigned XLEN = OTTER_XLEN
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_result_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_result_i,
  output logic [XLEN-1:0]   operand_c_o
);

  always_comb begin
    operand_c_o = rf_data_i;
    if (addr_i == '0) begin
      operand_c_o = '0;
    end else if (ex_regwrite_i && !ex_is_load_i && (ex_rd_i == addr_i)) begin
      operand_c_o = ex_result_i;
    end else if (mem_regwrite_i && (mem_rd_i == addr_i)) begin
      operand_c_o = mem_result_i;
    end
  end

endmodule

// File: rtl/otter_id_operand_stage.sv
// Decode-side operand stage: drives register-file addresses, bypasses EX/MEM results,
// inserts a load-use bubble, and holds the ID/EX pipeline register.
module otter_id_operand_stage
  import otter_pkg::*;
#(
  parameter int unsigned    XLEN     = OTTER_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_instr,
  input  logic [XLEN-1:0]   id_pc,
  output logic [REG_AW-1:0] rf_read1,
  output logic [REG_AW-1:0] rf_read2,
  input  logic [XLEN-1:0]   rf_data1,
  input  logic [XLEN-1:0]   rf_data2,
  input  logic              ex_fwd_regwrite,
  input  logic              ex_fwd_is_load,
  input  logic [REG_AW-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]   ex_fwd_result,
  input  logic              mem_fwd_regwrite,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_result,
  input  logic              flush,
  input  logic              stall_in,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_instr,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [REG_AW-1:0] ex_rd
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic              use_rs1;
  logic              use_rs2;
  logic              has_rd;
  logic              load_use;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;
  idex_t             idex_q;
  idex_t             idex_d;

  assign opcode   = id_instr[6:0];
  assign rs1      = id_instr[19:15];
  assign rs2      = id_instr[24:20];
  assign rd       = id_instr[11:7];
  assign use_rs1  = uses_rs1(opcode);
  assign use_rs2  = uses_rs2(opcode);
  assign has_rd   = rd_valid(opcode);
  assign rf_read1 = rs1;
  assign rf_read2 = rs2;

  otter_operand_fwd #(.XLEN(XLEN)) u_fwd_rs1 (
    .addr_i         (rs1),
    .rf_data_i      (rf_data1),
    .ex_regwrite_i  (ex_fwd_regwrite),
    .ex_is_load_i   (ex_fwd_is_load),
    .ex_rd_i        (ex_fwd_rd),
    .ex_result_i    (ex_fwd_result),
    .mem_regwrite_i (mem_fwd_regwrite),
    .mem_rd_i       (mem_fwd_rd),
    .mem_result_i   (mem_fwd_result),
    .operand_c_o    (rs1_fwd)
  );

  otter_operand_fwd #(.XLEN(XLEN)) u_fwd_rs2 (
    .addr_i         (rs2),
    .rf_data_i      (rf_data2),
    .ex_regwrite_i  (ex_fwd_regwrite),
    .ex_is_load_i   (ex_fwd_is_load),
    .ex_rd_i        (ex_fwd_rd),
    .ex_result_i    (ex_fwd_result),
    .mem_regwrite_i (mem_fwd_regwrite),
    .mem_rd_i       (mem_fwd_rd),
    .mem_result_i   (mem_fwd_result),
    .operand_c_o    (rs2_fwd)
  );

  // A load in EX whose rd feeds this instruction must wait one cycle to bypass from MEM.
  assign load_use = id_valid && ex_fwd_regwrite && ex_fwd_is_load && (ex_fwd_rd != '0) &&
                    ((use_rs1 && (rs1 == ex_fwd_rd)) || (use_rs2 && (rs2 == ex_fwd_rd)));
  assign stall_out = load_use || stall_in;

  // Next ID/EX contents: flush beats hold, hold beats bubble, bubble beats capture.
  always_comb begin
    idex_d = idex_q;
    if (flush || (!stall_in && load_use)) begin
      idex_d.valid = 1'b0;
      idex_d.rd    = '0;
      idex_d.instr = NOP_INSTR;
    end else if (!stall_in) begin
      idex_d.valid   = id_valid;
      idex_d.pc      = OTTER_XLEN'(id_pc);
      idex_d.instr   = INSTR_W'(id_instr);
      idex_d.rs1_val = OTTER_XLEN'(rs1_fwd);
      idex_d.rs2_val = OTTER_XLEN'(rs2_fwd);
      idex_d.rd      = (id_valid && has_rd) ? rd : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idex_q.valid   <= 1'b0;
      idex_q.pc      <= OTTER_XLEN'(RESET_PC);
      idex_q.instr   <= NOP_INSTR;
      idex_q.rs1_val <= '0;
      idex_q.rs2_val <= '0;
      idex_q.rd      <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid   = idex_q.valid;
  assign ex_pc      = XLEN'(idex_q.pc);
  assign ex_instr   = XLEN'(idex_q.instr);
  assign ex_rs1_val = XLEN'(idex_q.rs1_val);
  assign ex_rs2_val = XLEN'(idex_q.rs2_val);
  assign ex_rd      = idex_q.rd;

endmodule

// File: tb/tb_otter_id_operand_stage.sv
// Directed bench for the OTTER ID operand stage with hand-computed expectations.
module tb_otter_id_operand_stage;

  logic        clock;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [4:0]  rf_read1;
  logic [4:0]  rf_read2;
  logic [31:0] rf_data1;
  logic [31:0] rf_data2;
  logic        ex_fwd_regwrite;
  logic        ex_fwd_is_load;
  logic [4:0]  ex_fwd_rd;
  logic [31:0] ex_fwd_result;
  logic        mem_fwd_regwrite;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_result;
  logic        flush;
  logic        stall_in;
  logic        stall_out;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_pass   = 0;

  otter_id_operand_stage dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .id_valid         (id_valid),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .rf_read1         (rf_read1),
    .rf_read2         (rf_read2),
    .rf_data1         (rf_data1),
    .rf_data2         (rf_data2),
    .ex_fwd_regwrite  (ex_fwd_regwrite),
    .ex_fwd_is_load   (ex_fwd_is_load),
    .ex_fwd_rd        (ex_fwd_rd),
    .ex_fwd_result    (ex_fwd_result),
    .mem_fwd_regwrite (mem_fwd_regwrite),
    .mem_fwd_rd       (mem_fwd_rd),
    .mem_fwd_result   (mem_fwd_result),
    .flush            (flush),
    .stall_in         (stall_in),
    .stall_out        (stall_out),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_instr         (ex_instr),
    .ex_rs1_val       (ex_rs1_val),
    .ex_rs2_val       (ex_rs2_val),
    .ex_rd            (ex_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic no_fwd();
    ex_fwd_regwrite  = 1'b0;
    ex_fwd_is_load   = 1'b0;
    ex_fwd_rd        = 5'd0;
    ex_fwd_result    = 32'h0;
    mem_fwd_regwrite = 1'b0;
    mem_fwd_rd       = 5'd0;
    mem_fwd_result   = 32'h0;
  endtask

  initial begin
    reset_n  = 1'b0;
    id_valid = 1'b0;
    id_instr = 32'h0000_0013;
    id_pc    = 32'h0;
    rf_data1 = 32'h0;
    rf_data2 = 32'h0;
    flush    = 1'b0;
    stall_in = 1'b0;
    no_fwd();

    // Reset with clock running
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_pc",    ex_pc,         32'h0);
    check("rst_instr", ex_instr,      32'h13);
    check("rst_rd",    32'(ex_rd),    32'd0);
    check("rst_rs1",   ex_rs1_val,    32'h0);

    // add x3,x1,x2 : EX beats MEM on rs1
    id_valid = 1'b1; id_instr = 32'h0020_81B3; id_pc = 32'h100;
    rf_data1 = 32'd5; rf_data2 = 32'd8;
    ex_fwd_regwrite = 1'b1; ex_fwd_rd = 5'd1; ex_fwd_result = 32'd99;
    mem_fwd_regwrite = 1'b1; mem_fwd_rd = 5'd1; mem_fwd_result = 32'd7;
    #1;
    check("rd_addr1", 32'(rf_read1), 32'd1);
    check("rd_addr2", 32'(rf_read2), 32'd2);
    tick();
    check("exfwd_rs1",   ex_rs1_val,    32'd99);
    check("exfwd_rs2",   ex_rs2_val,    32'd8);
    check("exfwd_rd",    32'(ex_rd),    32'd3);
    check("exfwd_valid", 32'(ex_valid), 32'd1);
    check("exfwd_pc",    ex_pc,         32'h100);
    check("exfwd_instr", ex_instr,      32'h0020_81B3);

    // MEM bypass on rs2 while EX bypasses rs1
    mem_fwd_rd = 5'd2; mem_fwd_result = 32'h22;
    tick();
    check("memfwd_rs1", ex_rs1_val, 32'd99);
    check("memfwd_rs2", ex_rs2_val, 32'h22);

    // MEM bypass on rs1 when EX does not write
    ex_fwd_regwrite = 1'b0; mem_fwd_rd = 5'd1; mem_fwd_result = 32'd7;
    tick();
    check("memonly_rs1", ex_rs1_val, 32'd7);

    // add x3,x0,x2 : x0 never forwarded
    no_fwd();
    id_instr = 32'h0020_01B3; rf_data1 = 32'hDEAD;
    ex_fwd_regwrite = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_result = 32'd55;
    mem_fwd_regwrite = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_result = 32'd66;
    tick();
    check("x0_rs1", ex_rs1_val, 32'h0);

    // Load-use: lw x5 in EX, add x6,x5,x0 in ID
    no_fwd();
    id_instr = 32'h0002_8333; id_pc = 32'h200; rf_data1 = 32'h1;
    ex_fwd_regwrite = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd5; ex_fwd_result = 32'hBAD;
    #1;
    check("lu_stall1", 32'(stall_out), 32'd1);
    tick();
    check("lu_bub_valid", 32'(ex_valid), 32'd0);
    check("lu_bub_rd",    32'(ex_rd),    32'd0);
    check("lu_bub_instr", ex_instr,      32'h13);
    no_fwd();
    mem_fwd_regwrite = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_result = 32'h1234;
    #1;
    check("lu_stall2", 32'(stall_out), 32'd0);
    tick();
    check("lu_rs1",   ex_rs1_val,    32'h1234);
    check("lu_valid", 32'(ex_valid), 32'd1);
    check("lu_rd",    32'(ex_rd),    32'd6);

    // lui x6 (rs1 field aliases x5) after a load: no stall
    no_fwd();
    id_instr = 32'h0002_8337; id_pc = 32'h204;
    ex_fwd_regwrite = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd5;
    #1;
    check("lui_nostall", 32'(stall_out), 32'd0);
    tick();
    check("lui_valid", 32'(ex_valid), 32'd1);
    check("lui_rd",    32'(ex_rd),    32'd6);

    // Flush wins over stall_in
    no_fwd();
    stall_in = 1'b1; flush = 1'b1;
    #1;
    check("fl_stallout", 32'(stall_out), 32'd1);
    tick();
    check("fl_valid", 32'(ex_valid), 32'd0);
    check("fl_rd",    32'(ex_rd),    32'd0);
    check("fl_instr", ex_instr,      32'h13);

    // Capture, then hold under stall_in for 3 cycles
    stall_in = 1'b0; flush = 1'b0;
    id_instr = 32'h0020_81B3; id_pc = 32'h300; rf_data1 = 32'd5; rf_data2 = 32'd8;
    tick();
    stall_in = 1'b1;
    id_instr = 32'h0000_0013; id_pc = 32'h400; rf_data1 = 32'hAA; rf_data2 = 32'hBB;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 32'(ex_valid), 32'd1);
      check("hold_pc",    ex_pc,         32'h300);
      check("hold_instr", ex_instr,      32'h0020_81B3);
      check("hold_rs1",   ex_rs1_val,    32'd5);
      check("hold_rs2",   ex_rs2_val,    32'd8);
      check("hold_rd",    32'(ex_rd),    32'd3);
    end
    stall_in = 1'b0;

    // sw x7,0(x2) behind lw x7: stall on rs2, then store captured with rd 0
    id_instr = 32'h0071_2023; id_pc = 32'h500; rf_data1 = 32'h40; rf_data2 = 32'h0;
    ex_fwd_regwrite = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7;
    #1;
    check("st_stall", 32'(stall_out), 32'd1);
    tick();
    check("st_bub_valid", 32'(ex_valid), 32'd0);
    no_fwd();
    mem_fwd_regwrite = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_result = 32'h77;
    tick();
    check("st_valid", 32'(ex_valid), 32'd1);
    check("st_rd",    32'(ex_rd),    32'd0);
    check("st_rs1",   ex_rs1_val,    32'h40);
    check("st_rs2",   ex_rs2_val,    32'h77);

    // id_valid=0: no hazard, bubble captured
    no_fwd();
    id_valid = 1'b0;
    ex_fwd_regwrite = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7;
    #1;
    check("inv_nostall", 32'(stall_out), 32'd0);
    tick();
    check("inv_valid", 32'(ex_valid), 32'd0);
    check("inv_rd",    32'(ex_rd),    32'd0);

    // Async reset mid-cycle while stalled
    no_fwd();
    id_valid = 1'b1; id_instr = 32'h0020_81B3; id_pc = 32'h600;
    tick();
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    stall_in = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_pc",    ex_pc,         32'h0);
    check("arst_instr", ex_instr,      32'h13);
    check("arst_rd",    32'(ex_rd),    32'd0);
    tick();
    stall_in = 1'b0;
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
